store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised successor to the single-entry store busy tracker. Queues up to DEPTH stores (address + data + byte mask) from the execute stage in order. Drains them one at a time to the bus module through a req/done handshake. Reports busy/full/count to issue logic and optionally forwards buffered data to younger loads.

## Interface
- ADDR_W, 32, store address width
- DATA_W, 32, store data width; multiple of 8
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from execute
- st_ready  out  1  buffer can accept; = !full
- st_addr  in  ADDR_W  store address
- st_data  in  DATA_W  store data
- st_mask  in  DATA_W/8  byte enables
- bus_req  out  1  head store presented to bus module
- bus_addr  out  ADDR_W  head address
- bus_data  out  DATA_W  head data
- bus_mask  out  DATA_W/8  head byte enables
- bus_done  in  1  bus module finished head store (1-cycle pulse)
- ld_addr  in  ADDR_W  load address for forwarding lookup
- fwd_hit  out  1  buffered store matches ld_addr
- fwd_data  out  DATA_W  data of youngest matching entry
- busy  out  1  count != 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count register.
- Push: st_valid && st_ready at an edge writes {addr,data,mask} at wr_ptr, wr_ptr+1, count+1.
- Push when full is blocked. This holds even if a pop occurs in the same cycle; st_ready depends only on registered count.
- Drain FSM, two states:
  - IDLE: bus_req=0. If count != 0 at an edge → REQ.
  - REQ: bus_req=1. bus_addr/data/mask driven from the entry at rd_ptr and held stable. On bus_done → pop (rd_ptr+1, count−1) and → IDLE.
- bus_done while not in REQ is ignored and changes no state.
- Simultaneous push and pop in one edge: count unchanged, both pointers advance.
- bus_addr/data/mask are don't-care in IDLE. They are driven from the rd_ptr entry regardless.
- Stores drain strictly in acceptance order; no merging or reordering.

## Timing
- Reset values: bus_req=0, st_ready=1, busy=0, full=0, count=0, fwd_hit=0, fwd_data=0. Pointers are 0 and FSM is IDLE.
- A store accepted at edge N into an empty buffer → bus_req=1 after edge N+1.
- bus_done at edge M → bus_req=0 after M. If count is still nonzero, bus_req=1 again after M+1. This gives a minimum of 2 cycles per drained store with one idle gap.
- busy/full/count are registered and update at the push/pop edge.
- Reset asserted mid-operation discards all entries and drops bus_req at that edge. An outstanding bus transaction is abandoned, and the bus module must tolerate req withdrawal.
- Reset takes priority over push and bus_done in the same cycle.

## Configuration
- STORE_FWD_EN defined: fwd_hit/fwd_data are combinational from ld_addr and the occupied entries.
  - Match uses exact full-width address compare.
  - Among matches, the youngest (closest to wr_ptr) wins.
  - The head entry in REQ remains eligible until popped.
  - The mask is ignored for hit detection; fwd_data is the whole entry data.
- STORE_FWD_EN undefined: ports remain. fwd_hit is tied 0, fwd_data is tied 0, and no compare logic is built.

## Test plan
- Reset then single store addr=0x100 data=0xDEADBEEF mask=0xF → bus_req high 2 edges later with those values. bus_done → count 1→0, busy falls, bus_req=0.
- Fill DEPTH=4 with bus_done held low → full=1, st_ready=0. A 5th st_valid is not accepted. Drain with done pulses → bus_addr sequence matches push order, including pointer wrap after a 2nd fill.
- Full buffer, push and bus_done in the same cycle → push rejected and count=3. Non-full buffer with count=2, push and bus_done together → count stays 2.
- bus_done pulsed while IDLE (empty) → no count change and no pointer movement.
- rst asserted during REQ with count=3 → next cycle count=0, bus_req=0, st_ready=1. A following store drains normally.
- STORE_FWD_EN: entries 0x200→0x11, 0x204→0x22, 0x200→0x33; ld_addr=0x200 → fwd_hit=1, fwd_data=0x33. ld_addr=0x208 → fwd_hit=0. Without the macro → fwd_hit=0 always.

Source files
------------

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - handshake/bus bundle between execute, store_buffer and the bus module
//
// Parameters: ADDR_W, DATA_W (multiple of 8), DEPTH (power of two, >= 2)
// Signal groups:
//   st_*     : store acceptance from execute (st_valid/st_ready handshake)
//   bus_*    : head store presented to the bus module (bus_req/bus_done handshake)
//   ld_addr  : load address for forwarding lookup; fwd_hit/fwd_data result
//   busy/full/count : occupancy status to issue logic
// Modports: slave = store_buffer side, master = execute/bus/issue side.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) ();
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [MASK_W-1:0] st_mask;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic [MASK_W-1:0] bus_mask;
    logic              bus_done;

    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    logic              busy;
    logic              full;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  st_valid, st_addr, st_data, st_mask, bus_done, ld_addr,
        output st_ready, bus_req, bus_addr, bus_data, bus_mask,
               fwd_hit, fwd_data, busy, full, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_mask, bus_done, ld_addr,
        input  st_ready, bus_req, bus_addr, bus_data, bus_mask,
               fwd_hit, fwd_data, busy, full, count
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order DEPTH-entry store queue draining to the bus module
//
// Ports:
//   clk  : clock, all state changes on rising edge
//   rst  : synchronous active-high reset; discards all entries, drops bus_req
//   sbus : store_buffer_if.slave (store push, bus drain, load forwarding, status)
// Optional feature macro: STORE_FWD_EN
//   defined   -> fwd_hit/fwd_data compare ld_addr against occupied entries,
//                youngest match wins
//   undefined -> fwd_hit/fwd_data tied to 0, no compare logic
module store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sbus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [MASK_W-1:0] mask_mem [DEPTH];

    logic full_w;
    logic push;
    logic pop;

    // st_ready is a function of the registered count only, so a pop in the
    // same cycle never opens a slot for a push on a full buffer.
    assign full_w = (count_q == CNT_W'(DEPTH));
    assign push   = sbus.st_valid && !full_w;
    assign pop    = (state_q == S_REQ) && sbus.bus_done;

    // ---------------- drain FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- drain FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (count_q != '0)   state_d = S_REQ;
            S_REQ:  if (sbus.bus_done)   state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // ---------------- drain FSM: outputs ----------------
    logic bus_req_w;
    always_comb begin
        bus_req_w = 1'b0;
        unique case (state_q)
            S_IDLE:  bus_req_w = 1'b0;
            S_REQ:   bus_req_w = 1'b1;
            default: bus_req_w = 1'b0;
        endcase
    end

    // ---------------- pointers and occupancy ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_mem[wr_ptr_q] <= sbus.st_addr;
            data_mem[wr_ptr_q] <= sbus.st_data;
            mask_mem[wr_ptr_q] <= sbus.st_mask;
        end
    end

    assign sbus.st_ready = !full_w;
    assign sbus.bus_req  = bus_req_w;
    assign sbus.bus_addr = addr_mem[rd_ptr_q];
    assign sbus.bus_data = data_mem[rd_ptr_q];
    assign sbus.bus_mask = mask_mem[rd_ptr_q];
    assign sbus.busy     = (count_q != '0);
    assign sbus.full     = full_w;
    assign sbus.count    = count_q;

`ifdef STORE_FWD_EN
    // Walk oldest to youngest so a later match overwrites an earlier one.
    logic              fwd_hit_w;
    logic [DATA_W-1:0] fwd_data_w;
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit_w  = 1'b0;
        fwd_data_w = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem[idx] == sbus.ld_addr)) begin
                fwd_hit_w  = 1'b1;
                fwd_data_w = data_mem[idx];
            end
        end
    end
    assign sbus.fwd_hit  = fwd_hit_w;
    assign sbus.fwd_data = fwd_data_w;
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^sbus.ld_addr;
    assign sbus.fwd_hit   = 1'b0;
    assign sbus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking scoreboard bench for store_buffer
module tb_store_buffer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) sbif ();

    store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .sbus (sbif)
    );

    st_t sb_q[$];
    int  vectors = 0;
    int  errors  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the presented head against the oldest expected store and retire it.
    task automatic compare_head();
        st_t e;
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("bus_addr", 64'(sbif.bus_addr), 64'(e.a));
            check("bus_data", 64'(sbif.bus_data), 64'(e.d));
            check("bus_mask", 64'(sbif.bus_mask), 64'(e.m));
        end
    endtask

    // One clock with optional push and optional bus_done.
    task automatic cycle(input bit do_push, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit do_done);
        st_t e;
        sbif.st_valid = do_push;
        sbif.st_addr  = a;
        sbif.st_data  = d;
        sbif.st_mask  = m;
        sbif.bus_done = do_done;
        if (do_push && sbif.st_ready) begin
            e.a = a; e.d = d; e.m = m;
            sb_q.push_back(e);
        end
        if (do_done && sbif.bus_req) compare_head();
        tick();
        sbif.st_valid = 1'b0;
        sbif.bus_done = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sbif.bus_req && n < 8) begin
            tick();
            n++;
        end
        check("req_wait", 64'(sbif.bus_req), 64'd1);
    endtask

    task automatic drain_one();
        wait_req();
        if (sbif.bus_req) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            check("req_drop", 64'(sbif.bus_req), 64'd0);
        end
    endtask

    task automatic drain_all();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 16) begin
            drain_one();
            guard++;
        end
        check("drained_cnt", 64'(sbif.count), 64'd0);
    endtask

    initial begin
        sbif.st_valid = 1'b0;
        sbif.st_addr  = '0;
        sbif.st_data  = '0;
        sbif.st_mask  = '0;
        sbif.bus_done = 1'b0;
        sbif.ld_addr  = '0;

        // reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_req",   64'(sbif.bus_req),  64'd0);
        check("rst_ready", 64'(sbif.st_ready), 64'd1);
        check("rst_busy",  64'(sbif.busy),     64'd0);
        check("rst_full",  64'(sbif.full),     64'd0);
        check("rst_count", 64'(sbif.count),    64'd0);
        check("rst_hit",   64'(sbif.fwd_hit),  64'd0);
        check("rst_fdata", 64'(sbif.fwd_data), 64'd0);

        // single store: bus_req two edges after acceptance
        cycle(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
        check("one_cnt",  64'(sbif.count),   64'd1);
        check("one_busy", 64'(sbif.busy),    64'd1);
        check("one_req0", 64'(sbif.bus_req), 64'd0);
        tick();
        check("one_req1", 64'(sbif.bus_req), 64'd1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("one_cnt0", 64'(sbif.count),   64'd0);
        check("one_busy0",64'(sbif.busy),    64'd0);
        check("one_reqx", 64'(sbif.bus_req), 64'd0);

        // fill, reject 5th, partial drain, refill across pointer wrap
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h1000 + 32'(i*4), 32'hA000_0000 + 32'(i), 4'(i+1), 1'b0);
        check("fill_full",  64'(sbif.full),     64'd1);
        check("fill_ready", 64'(sbif.st_ready), 64'd0);
        check("fill_cnt",   64'(sbif.count),    64'd4);
        cycle(1'b1, 32'hBAD0, 32'hBAD0BAD0, 4'hF, 1'b0);
        check("fifth_cnt",  64'(sbif.count),    64'd4);
        drain_one();
        drain_one();
        check("half_cnt",   64'(sbif.count),    64'd2);
        cycle(1'b1, 32'h2000, 32'hB000_0000, 4'h3, 1'b0);
        cycle(1'b1, 32'h2004, 32'hB000_0001, 4'hC, 1'b0);
        check("wrap_cnt",   64'(sbif.count),    64'd4);
        drain_all();

        // full buffer: push and done together -> push rejected, count 3
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h3000 + 32'(i*4), 32'hC000_0000 + 32'(i), 4'hF, 1'b0);
        wait_req();
        cycle(1'b1, 32'h3FFC, 32'hC0FFEE00, 4'hF, 1'b1);
        check("fullpp_cnt", 64'(sbif.count), 64'd3);
        drain_one();
        check("cnt2", 64'(sbif.count), 64'd2);
        wait_req();
        cycle(1'b1, 32'h3100, 32'hC1000000, 4'h1, 1'b1);
        check("pp_cnt2", 64'(sbif.count), 64'd2);
        drain_all();

        // bus_done while idle and empty is ignored
        cycle(1'b0, '0, '0, '0, 1'b1);
        check("idle_done_cnt", 64'(sbif.count),    64'd0);
        check("idle_done_req", 64'(sbif.bus_req),  64'd0);
        tick();
        check("idle_done_req2",64'(sbif.bus_req),  64'd0);
        cycle(1'b1, 32'h4000, 32'h12345678, 4'h5, 1'b0);
        drain_all();

        // reset during REQ with three entries, also racing push and done
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5000 + 32'(i*4), 32'hD000_0000 + 32'(i), 4'hF, 1'b0);
        wait_req();
        check("pre_rst_cnt", 64'(sbif.count), 64'd3);
        rst = 1'b1;
        sbif.st_valid = 1'b1;
        sbif.st_addr  = 32'h5FFC;
        sbif.bus_done = 1'b1;
        tick();
        rst = 1'b0;
        sbif.st_valid = 1'b0;
        sbif.bus_done = 1'b0;
        sb_q.delete();
        check("mrst_cnt",   64'(sbif.count),    64'd0);
        check("mrst_req",   64'(sbif.bus_req),  64'd0);
        check("mrst_ready", 64'(sbif.st_ready), 64'd1);
        check("mrst_busy",  64'(sbif.busy),     64'd0);
        cycle(1'b1, 32'h6000, 32'h0BADF00D, 4'h9, 1'b0);
        drain_all();

        // forwarding
        sbif.ld_addr = 32'h200;
        #1;
        check("fwd_empty_hit", 64'(sbif.fwd_hit), 64'd0);
        cycle(1'b1, 32'h200, 32'h11, 4'hF, 1'b0);
        cycle(1'b1, 32'h204, 32'h22, 4'hF, 1'b0);
        cycle(1'b1, 32'h200, 32'h33, 4'h1, 1'b0);
        sbif.ld_addr = 32'h200;
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit",  64'(sbif.fwd_hit),  64'd1);
        check("fwd_data", 64'(sbif.fwd_data), 64'h33);
`else
        check("fwd_hit",  64'(sbif.fwd_hit),  64'd0);
        check("fwd_data", 64'(sbif.fwd_data), 64'd0);
`endif
        sbif.ld_addr = 32'h208;
        #1;
        check("fwd_miss", 64'(sbif.fwd_hit), 64'd0);
        sbif.ld_addr = 32'h204;
        #1;
`ifdef STORE_FWD_EN
        check("fwd_hit2",  64'(sbif.fwd_hit),  64'd1);
        check("fwd_data2", 64'(sbif.fwd_data), 64'h22);
`else
        check("fwd_hit2",  64'(sbif.fwd_hit),  64'd0);
`endif
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
